// File: rtl/cross_pkg.sv
// rtl/cross_pkg.sv - shared types and reciprocal-table helper for cross_timestamp
package cross_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_t;

    typedef enum logic {
        DISARMED = 1'b0,
        ARMED    = 1'b1
    } arm_state_t;

    // Entry i of the reciprocal table: min(floor(2^qw / i), 2^qw - 1); entry 0 is never read.
    function automatic longint unsigned recip_entry(input int unsigned i, input int unsigned qw);
        longint unsigned full;
        longint unsigned q;
        full = 64'd1 << qw;
        if (i == 0) begin
            q = full - 64'd1;
        end else begin
            q = full / 64'(i);
            if (q > full - 64'd1) begin
                q = full - 64'd1;
            end
        end
        return q;
    endfunction

endpackage

// File: rtl/cross_timestamp_recip_table.sv
// rtl/cross_timestamp_recip_table.sv - loadable reciprocal RAM with auto-increment write and sync read
module recip_table #(
    parameter int DW = 8,
    parameter int QW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          wr_en,
    input  logic [QW-1:0] wr_data,
    input  logic [DW:0]   rd_addr,
    output logic [QW-1:0] rd_data
);

    localparam int DEPTH = 1 << (DW + 1);

    logic [QW-1:0] mem [DEPTH];
    logic [DW:0]   wr_addr;
    logic          run_q;
    logic          wr_ok;

    assign wr_ok = !reset && !run && wr_en;

    // Address restarts on every run rising edge so each load begins at entry 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_addr <= '0;
            run_q   <= 1'b0;
        end else begin
            run_q <= run;
            if (run && !run_q) begin
                wr_addr <= '0;
            end else if (wr_ok) begin
                wr_addr <= wr_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/cross_timestamp.sv
// rtl/cross_timestamp.sv - level-crossing timestamper; optional arm hysteresis via CROSS_HYSTERESIS_EN
module cross_timestamp
    import cross_pkg::*;
#(
    parameter int DW  = 8,
    parameter int FW  = 8,
    parameter int QW  = 12,
    parameter int TSW = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    input  logic [1:0]     edge_mode,
    input  logic           tbl_wr_en,
    input  logic [QW-1:0]  tbl_wr_data,
    input  logic           in_valid,
    input  logic [DW-1:0]  vin,
    input  logic [DW-1:0]  vref,
`ifdef CROSS_HYSTERESIS_EN
    input  logic [DW-1:0]  hyst,
`endif
    output logic [TSW-1:0] t_int,
    output logic [FW-1:0]  t_frac,
    output logic           t_edge,
    output logic           t_valid
);

    localparam int PW = DW + 1 + QW;

    if (QW < FW) begin : g_bad_qw
        $error("cross_timestamp: QW must be >= FW");
    end

    logic signed [DW-1:0] v0;
    logic                 hist;
    logic [TSW-1:0]       cnt;
    logic                 accept;

    logic signed [DW-1:0] vin_s;
    logic signed [DW-1:0] vref_s;
    logic signed [DW:0]   v0_x;
    logic signed [DW:0]   v1_x;
    logic signed [DW:0]   ref_x;
    logic signed [DW:0]   diff;
    logic signed [DW:0]   num_s;
    logic [DW:0]          dv;

    logic rise_en;
    logic fall_en;
    logic rise_cross;
    logic fall_cross;
    logic rise_armed;
    logic fall_armed;
    logic hit_rise;
    logic hit_fall;

    assign accept = run && in_valid;
    assign vin_s  = vin;
    assign vref_s = vref;
    assign v0_x   = {v0[DW-1], v0};
    assign v1_x   = {vin[DW-1], vin};
    assign ref_x  = {vref[DW-1], vref};
    assign diff   = v1_x - v0_x;
    assign dv     = diff[DW] ? (DW+1)'(-diff) : diff;

    assign rise_en    = (edge_mode != 2'(EDGE_FALL));
    assign fall_en    = (edge_mode != 2'(EDGE_RISE));
    assign rise_cross = (v0 <= vref_s) && (vin_s > vref_s);
    assign fall_cross = (v0 > vref_s) && (vin_s <= vref_s);

    assign hit_rise = accept && hist && rise_en && rise_cross && rise_armed;
    assign hit_fall = accept && hist && fall_en && fall_cross && fall_armed;
    assign num_s    = hit_rise ? (ref_x - v0_x) : (v0_x - ref_x);

`ifdef CROSS_HYSTERESIS_EN
    arm_state_t rise_st;
    arm_state_t rise_nx;
    arm_state_t fall_st;
    arm_state_t fall_nx;
    logic signed [DW+1:0] vin_w;
    logic signed [DW+1:0] lo_w;
    logic signed [DW+1:0] hi_w;

    assign vin_w = {{2{vin[DW-1]}}, vin};
    assign lo_w  = {{2{vref[DW-1]}}, vref} - $signed({2'b00, hyst});
    assign hi_w  = {{2{vref[DW-1]}}, vref} + $signed({2'b00, hyst});

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            rise_st <= DISARMED;
            fall_st <= DISARMED;
        end else begin
            rise_st <= rise_nx;
            fall_st <= fall_nx;
        end
    end

    // A report and an arm on the same edge cannot coincide: arming lies on the far side of vref.
    always_comb begin
        rise_nx = rise_st;
        fall_nx = fall_st;
        if (accept) begin
            if (hit_rise) begin
                rise_nx = DISARMED;
            end else if (vin_w <= lo_w) begin
                rise_nx = ARMED;
            end
            if (hit_fall) begin
                fall_nx = DISARMED;
            end else if (vin_w >= hi_w) begin
                fall_nx = ARMED;
            end
        end
    end

    always_comb begin
        rise_armed = (rise_st == ARMED);
        fall_armed = (fall_st == ARMED);
    end
`else
    assign rise_armed = 1'b1;
    assign fall_armed = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            v0   <= '0;
            hist <= 1'b0;
            cnt  <= '0;
        end else if (!run) begin
            hist <= 1'b0;
        end else if (in_valid) begin
            v0   <= vin_s;
            hist <= 1'b1;
            cnt  <= cnt + 1'b1;
        end
    end

    logic [QW-1:0] tbl_q;

    recip_table #(
        .DW(DW),
        .QW(QW)
    ) u_recip_table (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .wr_en   (tbl_wr_en),
        .wr_data (tbl_wr_data),
        .rd_addr (dv),
        .rd_data (tbl_q)
    );

    logic           s1_valid;
    logic           s1_edge;
    logic [DW:0]    s1_num;
    logic [TSW-1:0] s1_t;
    logic           s2_valid;
    logic           s2_edge;
    logic [PW-1:0]  s2_prod;
    logic [TSW-1:0] s2_t;
    logic [PW-1:0]  prod_sh;

    // S1 registers line up with the table read issued in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_edge  <= 1'b0;
            s1_num   <= '0;
            s1_t     <= '0;
            s2_valid <= 1'b0;
            s2_edge  <= 1'b0;
            s2_prod  <= '0;
            s2_t     <= '0;
        end else begin
            s1_valid <= hit_rise || hit_fall;
            s1_edge  <= hit_rise;
            s1_num   <= num_s;
            s1_t     <= cnt - 1'b1;
            s2_valid <= s1_valid;
            s2_edge  <= s1_edge;
            s2_prod  <= PW'(s1_num) * PW'(tbl_q);
            s2_t     <= s1_t;
        end
    end

    assign prod_sh = s2_prod >> (QW - FW);

    always_ff @(posedge clk) begin
        if (reset) begin
            t_int   <= '0;
            t_frac  <= '0;
            t_edge  <= 1'b0;
            t_valid <= 1'b0;
        end else begin
            t_valid <= s2_valid;
            if (s2_valid) begin
                t_int  <= s2_t;
                t_edge <= s2_edge;
                t_frac <= (|prod_sh[PW-1:FW]) ? '1 : prod_sh[FW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_cross_timestamp.sv
// tb/tb_cross_timestamp.sv - directed self-checking bench for cross_timestamp
module tb_cross_timestamp;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [1:0]  edge_mode;
    logic        tbl_wr_en;
    logic [11:0] tbl_wr_data;
    logic        in_valid;
    logic [7:0]  vin;
    logic [7:0]  vref;
`ifdef CROSS_HYSTERESIS_EN
    logic [7:0]  hyst;
`endif
    logic [31:0] t_int;
    logic [7:0]  t_frac;
    logic        t_edge;
    logic        t_valid;

    int pass_cnt = 0;
    int total_cnt = 0;

    int          seq[$];
    int          obs_n;
    logic        obs_v [16];
    logic [31:0] obs_i [16];
    logic [7:0]  obs_f [16];
    logic        obs_e [16];

    always #5 clk = ~clk;

    cross_timestamp #(.DW(8), .FW(8), .QW(12), .TSW(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .edge_mode   (edge_mode),
        .tbl_wr_en   (tbl_wr_en),
        .tbl_wr_data (tbl_wr_data),
        .in_valid    (in_valid),
        .vin         (vin),
        .vref        (vref),
`ifdef CROSS_HYSTERESIS_EN
        .hyst        (hyst),
`endif
        .t_int       (t_int),
        .t_frac      (t_frac),
        .t_edge      (t_edge),
        .t_valid     (t_valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Sample 999 means an in_valid gap; obs[j] is the output state after edge j.
    task automatic play(input int n_idle);
        obs_n = seq.size() + n_idle;
        for (int j = 0; j < obs_n; j++) begin
            if (j < seq.size() && seq[j] != 999) begin
                in_valid = 1'b1;
                vin      = 8'(seq[j]);
            end else begin
                in_valid = 1'b0;
            end
            step();
            obs_v[j] = t_valid;
            obs_i[j] = t_int;
            obs_f[j] = t_frac;
            obs_e[j] = t_edge;
        end
        in_valid = 1'b0;
    endtask

    function automatic int nvalid();
        int n = 0;
        for (int j = 0; j < obs_n; j++) begin
            if (obs_v[j] === 1'b1) n++;
        end
        return n;
    endfunction

    task automatic load_table(input bit all_max);
        run = 1'b0;
        step();
        for (int i = 0; i < 512; i++) begin
            tbl_wr_en   = 1'b1;
            tbl_wr_data = all_max ? 12'hfff : 12'(cross_pkg::recip_entry(i, 12));
            step();
        end
        tbl_wr_en = 1'b0;
        run       = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        total_cnt++;
        if (t_valid !== 1'b0 || t_edge !== 1'b0) begin
            $display("FAIL reset_flags got valid=%b edge=%b want 0/0", t_valid, t_edge);
        end else pass_cnt++;
        total_cnt++;
        if (t_int !== 32'd0 || t_frac !== 8'd0) begin
            $display("FAIL reset_values got int=%0d frac=%0d want 0/0", t_int, t_frac);
        end else pass_cnt++;
    endtask

    task automatic test_rising();
        apply_reset();
        edge_mode = 2'd0;
        vref      = 8'd0;
        seq = {-10, 10};
        play(4);
        total_cnt++;
        if (nvalid() != 1 || obs_v[3] !== 1'b1) begin
            $display("FAIL rise_latency got count=%0d v3=%b want 1/1", nvalid(), obs_v[3]);
        end else pass_cnt++;
        total_cnt++;
        if (obs_f[3] !== 8'd127 || obs_e[3] !== 1'b1 || obs_i[3] !== 32'd0) begin
            $display("FAIL rise_result got frac=%0d edge=%b int=%0d want 127/1/0", obs_f[3], obs_e[3], obs_i[3]);
        end else pass_cnt++;
    endtask

    task automatic test_falling();
        apply_reset();
        edge_mode = 2'd1;
        vref      = 8'd0;
        seq = {30, -10};
        play(4);
        total_cnt++;
        if (nvalid() != 1 || obs_v[3] !== 1'b1) begin
            $display("FAIL fall_count got count=%0d v3=%b want 1/1", nvalid(), obs_v[3]);
        end else pass_cnt++;
        total_cnt++;
        if (obs_f[3] !== 8'd191 || obs_e[3] !== 1'b0 || obs_i[3] !== 32'd0) begin
            $display("FAIL fall_result got frac=%0d edge=%b int=%0d want 191/0/0", obs_f[3], obs_e[3], obs_i[3]);
        end else pass_cnt++;
        apply_reset();
        edge_mode = 2'd0;
        play(4);
        total_cnt++;
        if (nvalid() != 0) begin
            $display("FAIL fall_in_rise_mode got count=%0d want 0", nvalid());
        end else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_i [3];
        logic        exp_e [3];
        exp_i = '{32'd0, 32'd1, 32'd2};
        exp_e = '{1'b1, 1'b0, 1'b1};
        apply_reset();
        edge_mode = 2'd2;
        vref      = 8'd0;
        seq = {-50, 50, -50, 50};
        play(4);
        total_cnt++;
        if (nvalid() != 3) begin
            $display("FAIL both_count got %0d want 3", nvalid());
        end else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if (obs_v[3+k] !== 1'b1 || obs_i[3+k] !== exp_i[k] || obs_f[3+k] !== 8'd125
                || obs_e[3+k] !== exp_e[k]) begin
                $display("FAIL both_result%0d got v=%b int=%0d frac=%0d edge=%b want 1/%0d/125/%b",
                         k, obs_v[3+k], obs_i[3+k], obs_f[3+k], obs_e[3+k], exp_i[k], exp_e[k]);
            end else pass_cnt++;
        end
        apply_reset();
        edge_mode = 2'd3;
        play(4);
        total_cnt++;
        if (nvalid() != 3) begin
            $display("FAIL mode3_count got %0d want 3", nvalid());
        end else pass_cnt++;
    endtask

    task automatic test_gap();
        apply_reset();
        edge_mode = 2'd0;
        vref      = 8'd0;
        seq = {-10, 999, 999, 10};
        play(4);
        total_cnt++;
        if (nvalid() != 1 || obs_v[5] !== 1'b1 || obs_i[5] !== 32'd0 || obs_f[5] !== 8'd127) begin
            $display("FAIL gap_result got count=%0d v5=%b int=%0d frac=%0d want 1/1/0/127",
                     nvalid(), obs_v[5], obs_i[5], obs_f[5]);
        end else pass_cnt++;
    endtask

    task automatic test_boundaries();
        apply_reset();
        edge_mode = 2'd0;
        vref      = 8'd0;
        seq = {0, 1};
        play(4);
        total_cnt++;
        if (obs_v[3] !== 1'b1 || obs_f[3] !== 8'd0) begin
            $display("FAIL zero_frac got v=%b frac=%0d want 1/0", obs_v[3], obs_f[3]);
        end else pass_cnt++;
        apply_reset();
        vref = 8'd126;
        seq = {-128, 127};
        play(4);
        total_cnt++;
        if (obs_v[3] !== 1'b1 || obs_f[3] !== 8'd254 || obs_e[3] !== 1'b1) begin
            $display("FAIL full_span got v=%b frac=%0d edge=%b want 1/254/1", obs_v[3], obs_f[3], obs_e[3]);
        end else pass_cnt++;
        load_table(1'b1);
        apply_reset();
        vref = 8'd0;
        seq = {-10, 10};
        play(4);
        total_cnt++;
        if (obs_v[3] !== 1'b1 || obs_f[3] !== 8'd255) begin
            $display("FAIL saturate got v=%b frac=%0d want 1/255", obs_v[3], obs_f[3]);
        end else pass_cnt++;
        load_table(1'b0);
    endtask

    task automatic test_first_after_run();
        apply_reset();
        edge_mode = 2'd0;
        vref      = 8'd0;
        seq = {-10};
        play(0);
        run = 1'b0;
        step();
        run = 1'b1;
        seq = {10, -10, 10};
        play(4);
        total_cnt++;
        if (nvalid() != 1 || obs_v[4] !== 1'b1) begin
            $display("FAIL first_after_run got count=%0d v4=%b want 1/1", nvalid(), obs_v[4]);
        end else pass_cnt++;
        total_cnt++;
        if (obs_i[4] !== 32'd2) begin
            $display("FAIL counter_hold got int=%0d want 2", obs_i[4]);
        end else pass_cnt++;
    endtask

    task automatic test_write_while_run();
        apply_reset();
        run = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tbl_wr_en   = 1'b1;
            tbl_wr_data = 12'd0;
            step();
        end
        tbl_wr_en = 1'b0;
        edge_mode = 2'd0;
        vref      = 8'd0;
        seq = {-10, 10};
        play(4);
        total_cnt++;
        if (obs_v[3] !== 1'b1 || obs_f[3] !== 8'd127) begin
            $display("FAIL run_write_ignored got v=%b frac=%0d want 1/127", obs_v[3], obs_f[3]);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        apply_reset();
        edge_mode = 2'd0;
        vref      = 8'd0;
        seq = {-10, 10};
        play(0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (t_valid === 1'b1) seen++;
            step();
        end
        total_cnt++;
        if (seen != 0) begin
            $display("FAIL reset_discard got %0d strobes want 0", seen);
        end else pass_cnt++;
        play(4);
        total_cnt++;
        if (obs_v[3] !== 1'b1 || obs_i[3] !== 32'd0) begin
            $display("FAIL reset_recount got v=%b int=%0d want 1/0", obs_v[3], obs_i[3]);
        end else pass_cnt++;
    endtask

`ifdef CROSS_HYSTERESIS_EN
    task automatic test_hysteresis();
        apply_reset();
        edge_mode = 2'd0;
        vref      = 8'd0;
        hyst      = 8'd20;
        seq = {5, -5, 5, -25, 10};
        play(4);
        total_cnt++;
        if (nvalid() != 1 || obs_v[6] !== 1'b1) begin
            $display("FAIL hyst_count got count=%0d v6=%b want 1/1", nvalid(), obs_v[6]);
        end else pass_cnt++;
        total_cnt++;
        if (obs_i[6] !== 32'd3 || obs_f[6] !== 8'd182 || obs_e[6] !== 1'b1) begin
            $display("FAIL hyst_result got int=%0d frac=%0d edge=%b want 3/182/1", obs_i[6], obs_f[6], obs_e[6]);
        end else pass_cnt++;
        hyst = 8'd0;
    endtask
`endif

    initial begin
        reset       = 1'b1;
        run         = 1'b1;
        edge_mode   = 2'd0;
        tbl_wr_en   = 1'b0;
        tbl_wr_data = 12'd0;
        in_valid    = 1'b0;
        vin         = 8'd0;
        vref        = 8'd0;
`ifdef CROSS_HYSTERESIS_EN
        hyst        = 8'd0;
`endif
        test_reset();
        load_table(1'b0);
        test_rising();
        test_falling();
`ifndef CROSS_HYSTERESIS_EN
        test_back_to_back();
        test_gap();
        test_boundaries();
        test_first_after_run();
        test_write_while_run();
        test_reset_mid();
`else
        test_hysteresis();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
